// File: rtl/line_mem_ctrl_if.sv
// line_mem_ctrl_if: request/response bundle between the data cache and the
// backing-store line memory.
//   mem_enable_i  request valid, held by the cache until it sees the ack
//   mem_write_i   1 = write line, 0 = read line
//   mem_addr_i    byte address (bits [4:0] ignored)
//   mem_data_i    write line data
//   mem_data_o    read line data
//   mem_ack_o     one-cycle completion pulse
// The master modport is the cache side, the slave modport is the memory side.
interface line_mem_ctrl_if #(
    parameter int unsigned LINE_W = 256
);
    logic              mem_enable_i;
    logic              mem_write_i;
    logic [31:0]       mem_addr_i;
    logic [LINE_W-1:0] mem_data_i;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_ack_o;

    modport master (
        output mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
        input  mem_data_o, mem_ack_o
    );

    modport slave (
        input  mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
        output mem_data_o, mem_ack_o
    );
endinterface

// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: backing-store line memory behind the data cache.
// Accepts one whole-line read or write at a time and answers with a single-cycle
// ack after a fixed latency (IDLE -> BUSY -> ACK -> IDLE).
// Ports:
//   clk_i   system clock, rising edge
//   rst_i   asynchronous active-low reset (array contents are kept)
//   mem     line_mem_ctrl_if.slave request/response bundle
//   rd_count_o, wr_count_o, busy_cycles_o   saturating statistics counters,
//           present only when LINE_MEM_STATS_EN is defined
// Timing: a request accepted at edge N spends LATENCY-1 down to 0 in BUSY and
// acks in the cycle after edge N+LATENCY; LATENCY = 1 skips BUSY and acks in the
// cycle right after edge N. One request per LATENCY+2 cycles at most.
module line_mem_ctrl #(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 10,
    parameter int unsigned LINE_W  = 256
) (
    input logic             clk_i,
    input logic             rst_i,
    line_mem_ctrl_if.slave  mem
`ifdef LINE_MEM_STATS_EN
    ,
    output logic [31:0]     rd_count_o,
    output logic [31:0]     wr_count_o,
    output logic [31:0]     busy_cycles_o
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StAck  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q;
    logic [LINE_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_eff;
    logic              rd_load;

    // Byte offset and upper address bits are dropped, so addresses wrap mod DEPTH.
    assign req_idx = mem.mem_addr_i[5 +: IDX_W];

    logic unused_addr;
    assign unused_addr = ^{mem.mem_addr_i[31:5+IDX_W], mem.mem_addr_i[4:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            StIdle: begin
                if (mem.mem_enable_i) begin
                    wr_d    = mem.mem_write_i;
                    idx_d   = req_idx;
                    wdata_d = mem.mem_data_i;
                    if (LATENCY == 1) begin
                        state_d = StAck;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = 8'(LATENCY - 1);
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            // Enable is deliberately not sampled here: one turnaround cycle in IDLE.
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With LATENCY = 1 the edge that accepts a read also enters ACK, so the
    // request fields must come straight from the inputs rather than the latches.
    always_comb begin
        wr_eff  = (state_q == StIdle) ? mem.mem_write_i : wr_q;
        rd_idx  = (state_q == StIdle) ? req_idx : idx_q;
        rd_load = (state_d == StAck) && (state_q != StAck) && !wr_eff;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            if (rd_load) begin
                rdata_q <= mem_q[rd_idx];
            end
        end
    end

    // Write commits on the edge leaving ACK; a reset before then drops it.
    always_ff @(posedge clk_i) begin
        if (state_q == StAck && wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem.mem_data_o = rdata_q;
    assign mem.mem_ack_o  = (state_q == StAck);

`ifdef LINE_MEM_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_count_o    <= '0;
            wr_count_o    <= '0;
            busy_cycles_o <= '0;
        end else begin
            if (state_q == StAck && !wr_q && rd_count_o != '1) begin
                rd_count_o <= rd_count_o + 32'd1;
            end
            if (state_q == StAck && wr_q && wr_count_o != '1) begin
                wr_count_o <= wr_count_o + 32'd1;
            end
            if ((state_q == StBusy || state_q == StAck) && busy_cycles_o != '1) begin
                busy_cycles_o <= busy_cycles_o + 32'd1;
            end
        end
    end
`endif

endmodule
